vga_sync_monitor: RTL and testbench

Synthesizable receiver/checker for the VGA stream our display core drives (R[2:0], G[2:0], B[1:0], HS, VS). It re-derives sync-relative pixel/line position, measures line length and frame height, checks them against the configured mode, and reports lock and sticky errors. It also captures the colour at one programmable coordinate. It sits beside the display core in the top level and in benches, and is used for on-board self-check and for simulation of display modules.

---
 rtl/vga_sync_monitor.sv | 154 +++++++++++++++
 tb/tb_vga_sync_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// VGA stream receiver/checker: rebuilds sync-relative position, measures line/frame size and tracks mode lock.
// Optional probe capture is compiled in only when VGA_MON_PROBE_EN is defined.
module vga_sync_monitor #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int V_TOTAL = 521
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [2:0] R,
    input  logic [2:0] G,
    input  logic [1:0] B,
    input  logic       HS,
    input  logic       VS,
    input  logic       clr_err,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       frame_done,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] probe_rgb,
    output logic       probe_valid
);

    // state   | meaning
    // SEARCH  | no mode reference yet; nothing is checked
    // ACQUIRE | one frame boundary seen; lines checked, waiting for a clean full frame
    // LOCKED  | stream matches the configured mode
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [9:0]  H_SYNC_W  = 10'(H_SYNC);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;

    state_t      state, state_nxt;
    logic        hs_q, vs_q, have_line, h_seen;
    logic [9:0]  hs_low;
    logic        hs_fall, hs_rise, vs_fall;
    logic [10:0] hlen, vlen;
    logic [9:0]  hcnt_nxt, vcnt_nxt;
    logic        h_evt, v_evt;

    function automatic logic [9:0] sat10(input logic [10:0] v);
        return v[10] ? CNT_MAX : v[9:0];
    endfunction

    assign hs_fall = hs_q & ~HS;
    assign hs_rise = ~hs_q & HS;
    assign vs_fall = vs_q & ~VS;
    assign hlen    = {1'b0, hcnt} + 11'd1;
    assign vlen    = {1'b0, vcnt} + 11'd1;

    assign hcnt_nxt = hs_fall ? 10'd0 : sat10(hlen);
    assign vcnt_nxt = vs_fall ? 10'd0 : (hs_fall ? sat10(vlen) : vcnt);

    // have_line also guards the width check so a sync pulse cut by reset is never judged
    assign h_evt = pix_en && (state != SEARCH) && have_line &&
                   ((hs_fall && (hlen != H_TOTAL_W)) || (hs_rise && (hs_low != H_SYNC_W)));
    assign v_evt = pix_en && (state == LOCKED) && vs_fall && (vlen != V_TOTAL_W);

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (pix_en && vs_fall) state_nxt = ACQUIRE;
            ACQUIRE: if (pix_en && vs_fall && (vlen == V_TOTAL_W) && !h_seen && !h_evt)
                         state_nxt = LOCKED;
            LOCKED:  if (h_evt || v_evt) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            have_line   <= 1'b0;
            h_seen      <= 1'b0;
            hs_low      <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en) begin
                hs_q <= HS;
                vs_q <= VS;
                hcnt <= hcnt_nxt;
                vcnt <= vcnt_nxt;
                if (hs_fall) begin
                    if (have_line) line_len <= sat10(hlen);
                    have_line <= 1'b1;
                end
                if (hs_fall)                        hs_low <= 10'd1;
                else if (!HS && hs_low != CNT_MAX)  hs_low <= hs_low + 10'd1;
                if (vs_fall) begin
                    frame_lines <= sat10(vlen);
                    frame_done  <= 1'b1;
                end
                // each frame boundary opens a fresh acquisition window
                if (vs_fall)    h_seen <= 1'b0;
                else if (h_evt) h_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_err <= 1'b0;
            v_err <= 1'b0;
        end else begin
            if (h_evt)        h_err <= 1'b1;
            else if (clr_err) h_err <= 1'b0;
            if (v_evt)        v_err <= 1'b1;
            else if (clr_err) v_err <= 1'b0;
        end
    end

`ifdef VGA_MON_PROBE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            if (pix_en && (hcnt_nxt == probe_x) && (vcnt_nxt == probe_y)) begin
                probe_rgb   <= {R, G, B};
                probe_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_probe;
    assign unused_probe = ^{probe_x, probe_y, R, G, B};
    assign probe_rgb    = '0;
    assign probe_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a scaled-down 40x12 mode (HS low 6, VS low 2 lines).
module tb_vga_sync_monitor;
    localparam int HT = 40, HSW = 6, VT = 12, PX = 20, PY = 5;

    logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, clr_err = 1'b0;
    logic       HS = 1'b1, VS = 1'b1;
    logic [2:0] R = '0, G = '0;
    logic [1:0] B = '0;
    logic [9:0] probe_x = 10'(PX), probe_y = 10'(PY);
    logic [9:0] hcnt, vcnt, line_len, frame_lines;
    logic       frame_done, locked, h_err, v_err, probe_valid;
    logic [7:0] probe_rgb;

    vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HSW), .V_TOTAL(VT)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .R(R), .G(G), .B(B),
        .HS(HS), .VS(VS), .clr_err(clr_err), .probe_x(probe_x), .probe_y(probe_y),
        .hcnt(hcnt), .vcnt(vcnt), .line_len(line_len), .frame_lines(frame_lines),
        .frame_done(frame_done), .locked(locked), .h_err(h_err), .v_err(v_err),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   fl;
        int   ll;
        logic lk;
        logic he;
        logic ve;
    } frm_t;

    frm_t       frm_q[$];
    logic [7:0] prb_q[$];
    int n_vec = 0, n_bad = 0, probe_seen = 0, probe_exp = 0, vofs = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: pops the expected record whenever the DUT presents a frame or probe event
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                if (frm_q.size() == 0) chk("frame_done_extra", int'(frame_done), 0);
                else begin
                    frm_t e;
                    e = frm_q.pop_front();
                    chk("frame_lines", int'(frame_lines), e.fl);
                    chk("line_len",    int'(line_len),    e.ll);
                    chk("locked",      int'(locked),      int'(e.lk));
                    chk("h_err",       int'(h_err),       int'(e.he));
                    chk("v_err",       int'(v_err),       int'(e.ve));
                end
            end
            if (probe_valid) begin
                probe_seen++;
                if (prb_q.size() == 0) chk("probe_valid_extra", int'(probe_valid), 0);
                else                   chk("probe_rgb", int'(probe_rgb), int'(prb_q.pop_front()));
            end
        end
    end

    task automatic put(input logic hs, input logic vs, input logic [7:0] rgb, input logic clr);
        HS = hs; VS = vs; {R, G, B} = rgb; clr_err = clr; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0; clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hcnt"},        int'(hcnt),        0);
        chk({tag, "_vcnt"},        int'(vcnt),        0);
        chk({tag, "_line_len"},    int'(line_len),    0);
        chk({tag, "_frame_lines"}, int'(frame_lines), 0);
        chk({tag, "_locked"},      int'(locked),      0);
        chk({tag, "_h_err"},       int'(h_err),       0);
        chk({tag, "_v_err"},       int'(v_err),       0);
        chk({tag, "_frame_done"},  int'(frame_done),  0);
        chk({tag, "_probe_valid"}, int'(probe_valid), 0);
        chk({tag, "_probe_rgb"},   int'(probe_rgb),   0);
    endtask

    // One frame; the first sample is the VS fall that closes the previous frame, whose
    // expected report (efl..eve) is queued here. Optional faults/events use -1 to disable.
    task automatic drive_frame(input int nl, input int efl, input int ell,
                               input logic elk, input logic ehe, input logic eve,
                               input int short_y, input int short_len,
                               input int narrow_y, input int narrow_w,
                               input int pause_y, input int rst_y, input logic clr_evt);
        frm_t e;
        e = '{efl, ell, elk, ehe, eve};
        frm_q.push_back(e);
        vofs = 0;
        for (int y = 0; y < nl; y++) begin
            int len, hw;
            len = (y == short_y) ? short_len : HT;
            hw  = (y == narrow_y) ? narrow_w : HSW;
            for (int x = 0; x < len; x++) begin
                logic evt_clr;
                evt_clr = clr_evt && (y == short_y + 1) && (x == 0);
`ifdef VGA_MON_PROBE_EN
                if (x == PX && (y - vofs) == PY) begin
                    prb_q.push_back(8'(PX));
                    probe_exp++;
                end
`endif
                put((x < hw) ? 1'b0 : 1'b1, (y < 2) ? 1'b0 : 1'b1, x[7:0], evt_clr);
                if (short_y >= 0 && y == short_y + 1 && x == 0) begin
                    chk("short_line_h_err",    int'(h_err),    1);
                    chk("short_line_locked",   int'(locked),   0);
                    chk("short_line_line_len", int'(line_len), short_len);
                end
                if (y == narrow_y && x == hw) begin
                    chk("narrow_hs_h_err",  int'(h_err),  1);
                    chk("narrow_hs_locked", int'(locked), 0);
                end
                if (y == pause_y && x == 10) begin
                    repeat (20) @(negedge clk);
                    clr_err = 1'b1;
                    @(negedge clk);
                    clr_err = 1'b0;
                    repeat (29) @(negedge clk);
                    chk("pause_hcnt",  int'(hcnt),  10);
                    chk("pause_vcnt",  int'(vcnt),  pause_y);
                    chk("clr_h_err",   int'(h_err), 0);
                    chk("clr_v_err",   int'(v_err), 0);
                end
                if (y == rst_y && x == 15) begin
                    chk("pre_reset_vcnt", int'(vcnt), rst_y);
                    #2 rst_n = 1'b0;
                    #1 chk_all_zero("async_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    vofs  = rst_y;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: stimulus did not complete, vectors=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        //          nl  fl  ll lk he ve short     narrow  pause rst  clr
        drive_frame(12,  1,  0, 0, 0, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 1, 0, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 1, 0, 0,  5, 39,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 0, 1, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 1, 1, 0, -1,  0,  -1, 0,   7,  -1,  1'b0);
        drive_frame(11, 12, 40, 1, 0, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 11, 40, 0, 0, 1, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 0, 0, 1, -1,  0,   3, 5,  -1,  -1,  1'b0);
        drive_frame(12, 12, 40, 0, 1, 1,  4, 38,  -1, 0,   2,  -1,  1'b1);
        drive_frame(12, 12, 40, 0, 1, 0, -1,  0,  -1, 0,  -1,   6,  1'b0);
        drive_frame(12,  6, 40, 0, 0, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        drive_frame( 1, 12, 40, 1, 0, 0, -1,  0,  -1, 0,  -1,  -1,  1'b0);
        repeat (4) @(negedge clk);
        chk("frame_events_pending", frm_q.size(), 0);
        chk("probe_pulse_count", probe_seen, probe_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
